// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multicycle ALU.
//   OPCODE_W          width of the aluControl opcode
//   ALU_ADD..ALU_MUL  opcode encodings; values 11-15 are unassigned
//   alu_state_t       FSM state encoding (IDLE, MUL, DONE)
package alu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OPCODE_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OPCODE_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [OPCODE_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [OPCODE_W-1:0] ALU_XOR  = 4'd6;
  localparam logic [OPCODE_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [OPCODE_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [OPCODE_W-1:0] ALU_SRA  = 4'd9;
  localparam logic [OPCODE_W-1:0] ALU_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial-product step per cycle.
//   clk, reset  clock and synchronous active-high reset
//   start       load operands and begin WIDTH steps
//   a, b        multiplier / multiplicand, captured on start
//   busy        steps remain
//   done        this cycle performs the final step; product is the finished value
//   product     low WIDTH bits of a*b, valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] count;

  // Multiplicand shifts left each step, so bits beyond WIDTH fall off:
  // only the low WIDTH bits of the product are ever accumulated.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= b;
      mplier <= a;
      acc    <= '0;
      count  <= CNT_W'(WIDTH);
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
    end
  end

  assign busy    = (count != '0);
  assign done    = (count == CNT_W'(1));
  // Final step result is presented combinationally so the caller can
  // register it on the same edge the step completes.
  assign product = acc_next;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshake on both sides.
//   clk, reset          clock and synchronous active-high reset
//   inValid / inReady   operation handshake; captured when both high
//   srcA, srcB          operands (srcB low SHAMT_W bits are the shift amount)
//   aluControl          opcode (see alu_pkg)
//   outValid / outReady result handshake; consumed when both high
//   aluResult, zero     registered result and result==0 flag
//   illegal             opcode was unassigned
// Build option: ALU_MUL_EN enables the iterative multiplier for opcode 10;
// without it opcode 10 is reported illegal with single-cycle latency.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [WIDTH-1:0]    srcA,
  input  logic [WIDTH-1:0]    srcB,
  input  logic [OPCODE_W-1:0] aluControl,
  output logic                outValid,
  input  logic                outReady,
  output logic [WIDTH-1:0]    aluResult,
  output logic                zero,
  output logic                illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_t         state;
  logic               accept;
  logic               is_mul;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   comb_result;
  logic               comb_illegal;
  logic               mul_busy;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;

  assign inReady = (state == IDLE) || ((state == DONE) && outReady);
  assign accept  = inValid && inReady;
  assign shamt   = srcB[SHAMT_W-1:0];

`ifdef ALU_MUL_EN
  assign is_mul = (aluControl == ALU_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_mul),
    .a      (srcA),
    .b      (srcB),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Opcode 10 falls into the default arm: it is illegal unless the
  // multiplier is built, in which case is_mul diverts it to the MUL state.
  always_comb begin
    comb_result  = '0;
    comb_illegal = 1'b0;
    case (aluControl)
      ALU_ADD:  comb_result = srcA + srcB;
      ALU_SUB:  comb_result = srcA - srcB;
      ALU_AND:  comb_result = srcA & srcB;
      ALU_OR:   comb_result = srcA | srcB;
      ALU_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      ALU_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_XOR:  comb_result = srcA ^ srcB;
      ALU_SLL:  comb_result = srcA << shamt;
      ALU_SRL:  comb_result = srcA >> shamt;
      ALU_SRA:  comb_result = WIDTH'($signed(srcA) >>> shamt);
      default: begin
        comb_result  = '0;
        comb_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      outValid  <= 1'b0;
      aluResult <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              state    <= MUL;
              outValid <= 1'b0;
            end else begin
              state     <= DONE;
              outValid  <= 1'b1;
              aluResult <= comb_result;
              zero      <= (comb_result == '0);
              illegal   <= comb_illegal;
            end
          end else if ((state == DONE) && outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            state     <= DONE;
            outValid  <= 1'b1;
            aluResult <= mul_product;
            zero      <= (mul_product == '0);
            illegal   <= 1'b0;
          end else if (!mul_busy) begin
            // Multiplier idle without finishing: never strand the FSM.
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  aluControl;
  logic        outValid;
  logic        outReady;
  logic [31:0] aluResult;
  logic        zero;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   out_cycles[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   next_id  = 0;
  int   acc_cyc  = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .srcA      (srcA),
    .srcB      (srcB),
    .aluControl(aluControl),
    .outValid  (outValid),
    .outReady  (outReady),
    .aluResult (aluResult),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each consumed result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", aluResult);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result_%0d", e.id), aluResult, e.res);
        check($sformatf("zero_%0d", e.id), {31'b0, zero}, {31'b0, e.z});
        check($sformatf("illegal_%0d", e.id), {31'b0, illegal}, {31'b0, e.ill});
        out_cycles.push_back(cycle);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eill, input bit push);
    bit ok;
    exp_t e;
    if (push) begin
      e.res = er; e.z = (er == 32'd0); e.ill = eill; e.id = next_id;
      next_id++;
      exp_q.push_back(e);
    end
    inValid = 1'b1; aluControl = op; srcA = a; srcB = b;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cycle;
    // Scramble inputs after acceptance; the captured op must not change.
    inValid = 1'b0; srcA = $urandom; srcB = $urandom; aluControl = 4'(op + 4'd3);
  endtask

  task automatic drain;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    reset = 1'b1; inValid = 1'b0; srcA = '0; srcB = '0; aluControl = '0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outValid", {31'b0, outValid}, 32'd0);
    check("rst_aluResult", aluResult, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle ops, latency 1
    out_cycles.delete();
    issue(4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    drain();
    check("add_latency", out_cycles[0] - acc_cyc + 1, 32'd1);
    issue(4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1);
    issue(4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    issue(4'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
    issue(4'd9, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
    issue(4'd7, 32'd1, 32'h21, 32'd2, 1'b0, 1);
    issue(4'd8, 32'h80000000, 32'd31, 32'd1, 1'b0, 1);
    issue(4'd6, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1);
    issue(4'd2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1);
    issue(4'd3, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1);
    issue(4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
    issue(4'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1);
    issue(4'd15, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    drain();

    // Back-to-back adds: one result per cycle
    out_cycles.delete();
    issue(4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    issue(4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1);
    issue(4'd0, 32'd100, 32'd200, 32'd300, 1'b0, 1);
    issue(4'd0, 32'hFFFFFFFE, 32'd2, 32'd0, 1'b0, 1);
    drain();
    check("b2b_count", out_cycles.size(), 32'd4);
    bad = 0;
    for (int i = 1; i < out_cycles.size(); i++)
      if (out_cycles[i] != out_cycles[i-1] + 1) bad++;
    check("b2b_consecutive", bad, 32'd0);

    // Backpressure: result held with outReady low
    outReady = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (outValid !== 1'b1 || aluResult !== 32'd7 || zero !== 1'b0 || inReady !== 1'b0) bad++;
    end
    check("stall_hold", bad, 32'd0);
    @(posedge clk); #1 outReady = 1'b1;
    drain();

`ifdef ALU_MUL_EN
    out_cycles.delete();
    issue(4'd10, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (inReady !== 1'b0) bad++;
    end
    check("mul_inReady_low", bad, 32'd0);
    drain();
    check("mul_latency", out_cycles[0] - acc_cyc + 1, 32'd33);
    issue(4'd10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1);
    issue(4'd10, 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1);
    issue(4'd10, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1);
    drain();

    // Reset on cycle 10 of a multiply: nothing emitted
    issue(4'd10, 32'd77, 32'd99, 32'd0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mulrst_outValid", {31'b0, outValid}, 32'd0);
    check("mulrst_inReady", {31'b0, inReady}, 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (outValid !== 1'b0) bad++;
    end
    check("mulrst_no_output", bad, 32'd0);
    @(posedge clk); #1;
`else
    out_cycles.delete();
    issue(4'd10, 32'd1234, 32'd5678, 32'd0, 1'b1, 1);
    drain();
    check("mul_illegal_latency", out_cycles[0] - acc_cyc + 1, 32'd1);

    // Reset while a result is held: result discarded
    outReady = 1'b0;
    issue(4'd0, 32'd9, 32'd9, 32'd18, 1'b0, 0);
    @(negedge clk);
    check("held_before_rst", aluResult, 32'd18);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_held_outValid", {31'b0, outValid}, 32'd0);
    check("rst_held_result", aluResult, 32'd0);
    check("rst_held_inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk); #1 outReady = 1'b1;
`endif

    issue(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
